ws2812_rx: RTL and testbench

WS2812_RX -- requirements
Module: ws2812_rx

---
 rtl/ws2812_rx.sv | 201 ++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 serial-line receiver: decodes pixels and frames from the single-wire stream.
// Optional macro WS2812_RX_FORWARD_EN regenerates the line on do_o once NUM_LEDS pixels are captured.
module ws2812_rx #(
    parameter int NUM_LEDS     = 8,
    parameter int SYSTEM_CLOCK = 50000000
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       di_i,
    output logic [23:0]                pixel_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       frame_o,
    output logic [$clog2(NUM_LEDS):0]  led_count_o,
    output logic                       error_o,
    output logic                       overrun_o,
    output logic                       busy_o,
    output logic                       do_o
);

    localparam int T_BIT1 = SYSTEM_CLOCK * 3 / 5000000;
    localparam int T_LONG = SYSTEM_CLOCK / 500000;
    localparam int T_GAP  = SYSTEM_CLOCK / 20000;
    localparam int CW     = $clog2(T_GAP + 1);
    localparam int LCW    = $clog2(NUM_LEDS) + 1;

    localparam logic [CW-1:0]  BIT1_C  = CW'(T_BIT1);
    localparam logic [CW-1:0]  LONG_M1 = CW'(T_LONG - 1);
    localparam logic [CW-1:0]  GAP_M1  = CW'(T_GAP - 1);
    localparam logic [LCW-1:0] LED_MAX = LCW'(NUM_LEDS);

    typedef enum logic [2:0] {SYNC, IDLE, HIGH, LOW, ERR} state_t;

    state_t          state, state_n;
    logic [1:0]      sync_q;
    logic            line;
    logic [CW-1:0]   cnt, cnt_n;
    logic            bit_strobe, bit_val, gap, long_err;
    logic [4:0]      bit_cnt;
    logic [23:0]     shreg;
    logic [23:0]     new_pixel;
    logic [LCW-1:0]  pix_idx;
    logic            present;

    assign line      = sync_q[1];
    assign new_pixel = {shreg[22:0], bit_val};
    assign present   = bit_strobe && (bit_cnt == 5'd23) && (pix_idx < LED_MAX);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
            state  <= SYNC;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], di_i};
            state  <= state_n;
            cnt    <= cnt_n;
        end
    end

    // cnt holds the cycles already spent at the current level, so edge cycles load 1
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_strobe = 1'b0;
        bit_val    = 1'b0;
        gap        = 1'b0;
        long_err   = 1'b0;
        case (state)
            SYNC, ERR: begin
                if (line) begin
                    cnt_n = '0;
                end else if (cnt >= GAP_M1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (line) begin
                    state_n = HIGH;
                    cnt_n   = CW'(1);
                end
            end
            HIGH: begin
                if (line) begin
                    if (cnt >= LONG_M1) begin
                        state_n  = ERR;
                        cnt_n    = '0;
                        long_err = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    bit_strobe = 1'b1;
                    bit_val    = (cnt >= BIT1_C);
                    state_n    = LOW;
                    cnt_n      = CW'(1);
                end
            end
            LOW: begin
                if (line) begin
                    state_n = HIGH;
                    cnt_n   = CW'(1);
                end else if (cnt >= GAP_M1) begin
                    gap     = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = SYNC;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            pix_idx     <= '0;
            pixel_o     <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
            frame_o     <= 1'b0;
            error_o     <= 1'b0;
            busy_o      <= 1'b0;
            led_count_o <= '0;
        end else begin
            frame_o <= 1'b0;
            error_o <= 1'b0;
            if (state == IDLE && line) begin
                busy_o <= 1'b1;
            end
            if (bit_strobe) begin
                shreg   <= new_pixel;
                bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
            end
            // a consume in the completion cycle frees the slot, so the new pixel loads
            if (present) begin
                pix_idx <= pix_idx + 1'b1;
                if (!valid_o || ready_i) begin
                    pixel_o <= new_pixel;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            // a stuck-high line aborts the frame; resync happens in ERR
            if (long_err) begin
                error_o <= 1'b1;
                bit_cnt <= '0;
                pix_idx <= '0;
                busy_o  <= 1'b0;
            end
            if (gap) begin
                frame_o     <= 1'b1;
                led_count_o <= pix_idx;
                busy_o      <= 1'b0;
                pix_idx     <= '0;
                bit_cnt     <= '0;
                if (bit_cnt != 5'd0) begin
                    error_o <= 1'b1;
                end
            end
        end
    end

`ifdef WS2812_RX_FORWARD_EN
    logic fwd_on;
    logic fwd_start;
    logic do_q;

    assign fwd_start = (state == LOW) && line && (pix_idx == LED_MAX);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fwd_on <= 1'b0;
            do_q   <= 1'b0;
        end else begin
            if (gap || long_err) begin
                fwd_on <= 1'b0;
            end else if (fwd_start) begin
                fwd_on <= 1'b1;
            end
            do_q <= (fwd_on || fwd_start) && line;
        end
    end

    assign do_o = do_q;
`else
    assign do_o = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx at 50 MHz / NUM_LEDS=8; table of single-pixel frames plus corner sequences.
`timescale 1ns/1ps
module tb_ws2812_rx;

    localparam int NUM_LEDS     = 8;
    localparam int SYSTEM_CLOCK = 50000000;
    localparam int T0H = 20;
    localparam int T0L = 42;
    localparam int T1H = 40;
    localparam int T1L = 22;
    localparam int GAP_LOW = 2600;

    typedef struct {
        logic [23:0] wire_pix;
        logic [23:0] exp_pix;
        logic        exp_valid;
        logic [3:0]  exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        di;
    logic        ready;
    logic [23:0] pixel;
    logic        valid;
    logic        frame;
    logic [$clog2(NUM_LEDS):0] led_count;
    logic        error;
    logic        overrun;
    logic        busy;
    logic        do_line;

    int vec_count = 0;
    int miss_count = 0;
    int frame_cnt = 0;
    int err_cnt = 0;
    int do_hi = 0;
    logic [23:0] got_q[$];

    vec_t        vecs[4];
    logic [23:0] burst[10];

    ws2812_rx #(.NUM_LEDS(NUM_LEDS), .SYSTEM_CLOCK(SYSTEM_CLOCK)) dut (
        .clk_i(clk), .reset_i(rst), .di_i(di), .pixel_o(pixel), .valid_o(valid),
        .ready_i(ready), .frame_o(frame), .led_count_o(led_count), .error_o(error),
        .overrun_o(overrun), .busy_o(busy), .do_o(do_line)
    );

    always #10 clk = ~clk;

    // Pulse counters and consumed-pixel log, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (frame) frame_cnt++;
            if (error) err_cnt++;
            if (do_line) do_hi++;
            if (valid && ready) got_q.push_back(pixel);
        end
    end

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task send_bit(input logic b);
        di = 1'b1;
        tick(b ? T1H : T0H);
        di = 1'b0;
        tick(b ? T1L : T0L);
    endtask

    task send_bits(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task applyStimulus(input vec_t v);
        ready = 1'b0;
        send_bits(v.wire_pix, 24);
    endtask

    task consume();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    function automatic int high_cycles(input logic [23:0] v);
        int s = 0;
        for (int i = 0; i < 24; i++) s += v[i] ? T1H : T0H;
        return s;
    endfunction

    task check_all_zero(input string tag);
        checkOutput({tag, " pixel"}, 32'(pixel), 32'h0);
        checkOutput({tag, " valid"}, 32'(valid), 32'h0);
        checkOutput({tag, " led_count"}, 32'(led_count), 32'h0);
        checkOutput({tag, " overrun"}, 32'(overrun), 32'h0);
        checkOutput({tag, " busy"}, 32'(busy), 32'h0);
        checkOutput({tag, " frame"}, 32'(frame), 32'h0);
        checkOutput({tag, " error"}, 32'(error), 32'h0);
        checkOutput({tag, " do"}, 32'(do_line), 32'h0);
    endtask

    initial begin
        int f0, e0, q0, d0, exp_do;
        vecs[0] = '{24'hA5C3F0, 24'hA5C3F0, 1'b1, 4'd1};
        vecs[1] = '{24'h000000, 24'h000000, 1'b1, 4'd1};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 4'd1};
        vecs[3] = '{24'h800001, 24'h800001, 1'b1, 4'd1};
        burst = '{24'h010203, 24'h102030, 24'hABCDEF, 24'h00FF00, 24'hFF0000,
                  24'h0000FF, 24'h135790, 24'h2468AC, 24'h5555AA, 24'hAA5555};

        di = 1'b0;
        ready = 1'b0;
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        check_all_zero("reset");
        tick(1);
        rst = 1'b0;
        tick(GAP_LOW);

        // Single-pixel frames
        for (int k = 0; k < 4; k++) begin
            f0 = frame_cnt;
            e0 = err_cnt;
            applyStimulus(vecs[k]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d busy", k), 32'(busy), 32'h1);
            tick(GAP_LOW);
            @(negedge clk);
            checkOutput($sformatf("vec%0d pixel", k), 32'(pixel), 32'(vecs[k].exp_pix));
            checkOutput($sformatf("vec%0d valid", k), 32'(valid), 32'(vecs[k].exp_valid));
            checkOutput($sformatf("vec%0d led_count", k), 32'(led_count), 32'(vecs[k].exp_cnt));
            checkOutput($sformatf("vec%0d frames", k), 32'(frame_cnt - f0), 32'd1);
            checkOutput($sformatf("vec%0d errors", k), 32'(err_cnt - e0), 32'd0);
            checkOutput($sformatf("vec%0d busy_end", k), 32'(busy), 32'h0);
            consume();
            @(negedge clk);
            checkOutput($sformatf("vec%0d consumed", k), 32'(valid), 32'h0);
        end

        // Consume coinciding with the next completion: new pixel loads, no overrun
        ready = 1'b0;
        send_bits(24'h0F0F0F, 24);
        for (int i = 23; i >= 1; i--) send_bit(1'(24'hC0FFEE >> i));
        di = 1'b1;
        tick(T0H);
        di = 1'b0;
        tick(2);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(GAP_LOW);
        @(negedge clk);
        checkOutput("coinc pixel", 32'(pixel), 32'hC0FFEE);
        checkOutput("coinc valid", 32'(valid), 32'h1);
        checkOutput("coinc overrun", 32'(overrun), 32'h0);
        checkOutput("coinc led_count", 32'(led_count), 32'd2);
        consume();

        // Overrun with ready held low
        send_bits(24'h000001, 24);
        send_bits(24'hFFFFFF, 24);
        tick(GAP_LOW);
        @(negedge clk);
        checkOutput("ovr pixel", 32'(pixel), 32'h000001);
        checkOutput("ovr valid", 32'(valid), 32'h1);
        checkOutput("ovr overrun", 32'(overrun), 32'h1);
        consume();
        @(negedge clk);
        checkOutput("ovr consumed", 32'(valid), 32'h0);
        checkOutput("ovr sticky", 32'(overrun), 32'h1);

        // Truncated pixel at the gap
        f0 = frame_cnt;
        e0 = err_cnt;
        send_bits(24'h000ABC, 12);
        tick(GAP_LOW);
        @(negedge clk);
        checkOutput("trunc errors", 32'(err_cnt - e0), 32'd1);
        checkOutput("trunc frames", 32'(frame_cnt - f0), 32'd1);
        checkOutput("trunc valid", 32'(valid), 32'h0);
        checkOutput("trunc led_count", 32'(led_count), 32'd0);

        // Over-long high mid-frame, then resync
        f0 = frame_cnt;
        e0 = err_cnt;
        send_bits(24'h00001B, 5);
        di = 1'b1;
        tick(120);
        di = 1'b0;
        tick(100);
        send_bits(24'h777777, 24);
        tick(GAP_LOW);
        @(negedge clk);
        checkOutput("long errors", 32'(err_cnt - e0), 32'd1);
        checkOutput("long frames", 32'(frame_cnt - f0), 32'd0);
        checkOutput("long valid", 32'(valid), 32'h0);
        f0 = frame_cnt;
        send_bits(24'h3C3C3C, 24);
        tick(GAP_LOW);
        @(negedge clk);
        checkOutput("resync pixel", 32'(pixel), 32'h3C3C3C);
        checkOutput("resync valid", 32'(valid), 32'h1);
        checkOutput("resync led_count", 32'(led_count), 32'd1);
        checkOutput("resync frames", 32'(frame_cnt - f0), 32'd1);
        checkOutput("resync errors", 32'(err_cnt - e0), 32'd1);
        consume();

        // Ten pixels into an eight-LED receiver
        tick(1);
        q0 = got_q.size();
        d0 = do_hi;
        ready = 1'b1;
        for (int k = 0; k < 10; k++) send_bits(burst[k], 24);
        tick(GAP_LOW);
        ready = 1'b0;
        @(negedge clk);
        checkOutput("burst presented", 32'(got_q.size() - q0), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (q0 + k < got_q.size())
                checkOutput($sformatf("burst pix%0d", k), 32'(got_q[q0 + k]), 32'(burst[k]));
        end
        checkOutput("burst led_count", 32'(led_count), 32'd8);
`ifdef WS2812_RX_FORWARD_EN
        exp_do = high_cycles(burst[8]) + high_cycles(burst[9]);
`else
        exp_do = 0;
`endif
        checkOutput("burst do high cycles", 32'(do_hi - d0), 32'(exp_do));
        checkOutput("burst overrun sticky", 32'(overrun), 32'h1);

        // Reset asserted in the middle of a high pulse
        send_bits(24'h00002D, 6);
        di = 1'b1;
        tick(10);
        checkOutput("pre-reset busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #2;
        check_all_zero("midreset");
        tick(3);
        di = 1'b0;
        rst = 1'b0;
        tick(GAP_LOW);
        e0 = err_cnt;
        send_bits(24'h5A0F3C, 24);
        tick(GAP_LOW);
        @(negedge clk);
        checkOutput("post-reset pixel", 32'(pixel), 32'h5A0F3C);
        checkOutput("post-reset valid", 32'(valid), 32'h1);
        checkOutput("post-reset led_count", 32'(led_count), 32'd1);
        checkOutput("post-reset errors", 32'(err_cnt - e0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
